// File: rtl/spi_flash_responder_if.sv
// spi_flash_responder_if: SPI pin bundle plus the request/valid byte port of the flash responder
interface spi_flash_responder_if;
    logic        spi_sclk;
    logic        spi_csb;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_miso_oe;
    logic        mem_req;
    logic [23:0] mem_addr;
    logic        mem_valid;
    logic [7:0]  mem_rdata;

    modport master (
        output spi_sclk, spi_csb, spi_mosi, mem_valid, mem_rdata,
        input  spi_miso, spi_miso_oe, mem_req, mem_addr
    );

    modport slave (
        input  spi_sclk, spi_csb, spi_mosi, mem_valid, mem_rdata,
        output spi_miso, spi_miso_oe, mem_req, mem_addr
    );
endinterface

// File: rtl/spi_flash_responder.sv
// spi_flash_responder: SPI mode-0 flash READ (0x03) target streaming bytes from a request/valid port; SPI_FAST_READ_EN adds 0x0B with 8 dummy clocks
module spi_flash_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    spi_flash_responder_if.slave bus,
    output logic                 busy,
    output logic                 err_cmd,
    output logic                 underrun
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_IGNORE = 3'd4;
`ifdef SPI_FAST_READ_EN
    localparam logic [2:0] S_DUMMY  = 3'd5;
    logic fast;
`endif

    logic [SYNC_STAGES-1:0] sclk_q, csb_q, mosi_q;
    logic        sclk_d, sclk_s, csb_s, mosi_s, rise, fall, cmd_ok;
    logic [2:0]  state;
    logic [4:0]  cnt;
    logic [22:0] sh;
    logic [23:0] addr;
    logic [7:0]  cmd_byte, buf_q, shf;
    logic        buf_vld, pend, req, oe;

    assign sclk_s   = sclk_q[SYNC_STAGES-1];
    assign csb_s    = csb_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_q[SYNC_STAGES-1];
    assign rise     = sclk_s & ~sclk_d;
    assign fall     = ~sclk_s & sclk_d;
    assign cmd_byte = {sh[6:0], mosi_s};
`ifdef SPI_FAST_READ_EN
    assign cmd_ok   = (cmd_byte == 8'h03) || (cmd_byte == 8'h0B);
`else
    assign cmd_ok   = cmd_byte == 8'h03;
`endif
    assign busy            = ~csb_s;
    assign bus.spi_miso    = oe & shf[7];
    assign bus.spi_miso_oe = oe;
    assign bus.mem_req     = req;
    assign bus.mem_addr    = addr;

    // Synchronize the asynchronous SPI pins and keep one extra SCLK sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_q <= '0;
            csb_q  <= '1;
            mosi_q <= '0;
            sclk_d <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], bus.spi_sclk};
            csb_q  <= {csb_q[SYNC_STAGES-2:0], bus.spi_csb};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], bus.spi_mosi};
            sclk_d <= sclk_s;
        end
    end

    // Protocol FSM: command/address capture, byte buffer fill, and MISO shifting; csb high overrides any SCLK edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            sh       <= '0;
            addr     <= '0;
            buf_q    <= '0;
            shf      <= '0;
            buf_vld  <= 1'b0;
            pend     <= 1'b0;
            req      <= 1'b0;
            oe       <= 1'b0;
            err_cmd  <= 1'b0;
            underrun <= 1'b0;
`ifdef SPI_FAST_READ_EN
            fast     <= 1'b0;
`endif
        end else begin
            req     <= 1'b0;
            err_cmd <= 1'b0;
            if (bus.mem_valid && pend) begin
                buf_q   <= bus.mem_rdata;
                buf_vld <= 1'b1;
                pend    <= 1'b0;
            end
            if (csb_s) begin
                state    <= S_IDLE;
                cnt      <= '0;
                pend     <= 1'b0;
                buf_vld  <= 1'b0;
                oe       <= 1'b0;
                shf      <= '0;
                underrun <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        state <= S_CMD;
                        cnt   <= '0;
                    end
                    S_CMD: if (rise) begin
                        sh  <= {sh[21:0], mosi_s};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt     <= '0;
                            state   <= cmd_ok ? S_ADDR : S_IGNORE;
                            err_cmd <= ~cmd_ok;
`ifdef SPI_FAST_READ_EN
                            fast    <= cmd_byte == 8'h0B;
`endif
                        end
                    end
                    S_ADDR: if (rise) begin
                        sh  <= {sh[21:0], mosi_s};
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd23) begin
                            cnt     <= '0;
                            addr    <= {sh, mosi_s};
                            req     <= 1'b1;
                            pend    <= 1'b1;
                            buf_vld <= 1'b0;
`ifdef SPI_FAST_READ_EN
                            state   <= fast ? S_DUMMY : S_DATA;
`else
                            state   <= S_DATA;
`endif
                        end
                    end
`ifdef SPI_FAST_READ_EN
                    S_DUMMY: if (rise) begin
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            cnt   <= '0;
                            state <= S_DATA;
                        end
                    end
`endif
                    S_DATA: if (fall) begin
                        cnt <= {2'b00, cnt[2:0] + 3'd1};
                        if (cnt[2:0] == 3'd0) begin
                            shf      <= buf_vld ? buf_q : 8'hFF;
                            underrun <= underrun | ~buf_vld;
                            addr     <= addr + 24'd1;
                            req      <= 1'b1;
                            pend     <= 1'b1;
                            buf_vld  <= 1'b0;
                            oe       <= 1'b1;
                        end else begin
                            shf <= {shf[6:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_responder.sv
// tb_spi_flash_responder: randomized READ transfers against a behavioural flash model with queue scoreboards
`timescale 1ns/1ps
module tb_spi_flash_responder;
    localparam int HALF = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy, err_cmd, underrun;

    spi_flash_responder_if bus();

    spi_flash_responder #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .busy(busy), .err_cmd(err_cmd), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int req_cnt = 0;
    int err_cnt = 0;
    int oe_cnt = 0;
    int resp_idx = 0;
    int skip_idx = -1;
    int nbits = 0;
    logic [7:0]  rx = '0;
    logic [23:0] exp_addr_q[$];
    logic [7:0]  exp_byte_q[$];
    bit          bits_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Flash contents: the test-plan bytes at 0x10..0x12, a fixed hash of the address elsewhere
    function automatic logic [7:0] mem_of(input logic [23:0] a);
        case (a)
            24'h000010: return 8'hA1;
            24'h000011: return 8'hB2;
            24'h000012: return 8'hC3;
            default:    return (a[7:0] * 8'd7) ^ a[15:8] ^ a[23:16] ^ 8'h5A;
        endcase
    endfunction

    // Model of a READ: one request per byte plus the prefetch after the last, bytes read in address order
    task automatic expect_read(input logic [23:0] a, input int n, input bit withheld);
        for (int i = 0; i <= n; i++) exp_addr_q.push_back(a + 24'(i));
        for (int i = 0; i < n; i++) exp_byte_q.push_back((i == 0 && withheld) ? 8'hFF : mem_of(a + 24'(i)));
    endtask

    task automatic push_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) bits_q.push_back(b[i]);
    endtask

    task automatic push_addr(input logic [23:0] a);
        for (int i = 23; i >= 0; i--) bits_q.push_back(a[i]);
    endtask

    task automatic push_zeros(input int n);
        repeat (n) bits_q.push_back(1'b0);
    endtask

    task automatic start_cs();
        @(negedge clk);
        bus.spi_csb = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send_bits(input bit chk_ur, input bit ur_exp);
        while (bits_q.size() > 0) begin
            if (bits_q.size() == 1 && chk_ur) chk("underrun_active", 32'(underrun), 32'(ur_exp));
            bus.spi_mosi = bits_q.pop_front();
            repeat (HALF) @(negedge clk);
            bus.spi_sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            bus.spi_sclk = 1'b0;
        end
    endtask

    task automatic end_cs();
        bus.spi_csb = 1'b1;
        repeat (8) @(negedge clk);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("oe_idle", 32'(bus.spi_miso_oe), 32'd0);
        chk("underrun_cleared", 32'(underrun), 32'd0);
    endtask

    task automatic xfer(input bit chk_ur, input bit ur_exp);
        start_cs();
        send_bits(chk_ur, ur_exp);
        end_cs();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_miso"}, 32'(bus.spi_miso), 32'd0);
        chk({tag, "_oe"}, 32'(bus.spi_miso_oe), 32'd0);
        chk({tag, "_req"}, 32'(bus.mem_req), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_err"}, 32'(err_cmd), 32'd0);
        chk({tag, "_underrun"}, 32'(underrun), 32'd0);
    endtask

    // Request monitor: every mem_req pops the next expected address
    always @(negedge clk) begin
        if (bus.mem_req) begin
            req_cnt++;
            if (exp_addr_q.size() == 0) begin
                n_total++;
                $display("FAIL mem_req_unexpected: got request for %0h, expected none", bus.mem_addr);
            end else begin
                chk("mem_addr", 32'(bus.mem_addr), 32'(exp_addr_q.pop_front()));
            end
        end
        if (bus.spi_miso_oe) oe_cnt++;
        if (err_cmd) err_cnt++;
    end

    // MISO monitor: assemble bytes on rising SCLK while the DUT drives, compare each complete byte
    always @(posedge bus.spi_sclk or posedge bus.spi_csb or posedge rst) begin
        if (rst || bus.spi_csb) begin
            nbits = 0;
        end else if (bus.spi_miso_oe) begin
            rx = {rx[6:0], bus.spi_miso};
            nbits++;
            if (nbits == 8) begin
                nbits = 0;
                if (exp_byte_q.size() == 0) begin
                    n_total++;
                    $display("FAIL miso_unexpected: got byte %0h, expected none", rx);
                end else begin
                    chk("miso_byte", 32'(rx), 32'(exp_byte_q.pop_front()));
                end
            end
        end
    end

    // Memory responder: answers each request after 0..2 extra cycles, except the one selected by skip_idx
    initial begin
        logic [23:0] a;
        int d;
        bus.mem_valid = 1'b0;
        bus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (bus.mem_req) begin
                a = bus.mem_addr;
                d = $urandom_range(0, 2);
                if (resp_idx != skip_idx) begin
                    repeat (d) @(negedge clk);
                    bus.mem_valid = 1'b1;
                    bus.mem_rdata = mem_of(a);
                    @(negedge clk);
                    bus.mem_valid = 1'b0;
                end
                resp_idx++;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, r0, o0, n;
        logic [23:0] a;
        bus.spi_sclk = 1'b0;
        bus.spi_csb  = 1'b1;
        bus.spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        repeat (4) @(negedge clk);

        push_byte(8'h03); push_addr(24'h000010); push_zeros(24);
        expect_read(24'h000010, 3, 1'b0);
        xfer(1'b1, 1'b0);

        e0 = err_cnt; r0 = req_cnt; o0 = oe_cnt;
        push_byte(8'h9F); push_zeros(16);
        xfer(1'b0, 1'b0);
        chk("err_9f_pulses", 32'(err_cnt - e0), 32'd1);
        chk("oe_9f_cycles", 32'(oe_cnt - o0), 32'd0);
        chk("req_9f_count", 32'(req_cnt - r0), 32'd0);

        r0 = req_cnt;
        a = 24'hABCDEF;
        push_byte(8'h03);
        for (int i = 23; i >= 12; i--) bits_q.push_back(a[i]);
        xfer(1'b0, 1'b0);
        chk("req_abort_count", 32'(req_cnt - r0), 32'd0);
        push_byte(8'h03); push_addr(24'h000000); push_zeros(16);
        expect_read(24'h000000, 2, 1'b0);
        xfer(1'b1, 1'b0);

        push_byte(8'h03); push_addr(24'hFFFFFF); push_zeros(16);
        expect_read(24'hFFFFFF, 2, 1'b0);
        xfer(1'b1, 1'b0);

        skip_idx = resp_idx;
        push_byte(8'h03); push_addr(24'h123456); push_zeros(16);
        expect_read(24'h123456, 2, 1'b1);
        xfer(1'b1, 1'b1);
        skip_idx = -1;

        for (int k = 0; k < 6; k++) begin
            a = 24'($urandom);
            n = $urandom_range(1, 4);
            push_byte(8'h03); push_addr(a); push_zeros(8 * n);
            expect_read(a, n, 1'b0);
            xfer(1'b1, 1'b0);
        end

        exp_addr_q.push_back(24'h000040);
        exp_addr_q.push_back(24'h000041);
        push_byte(8'h03); push_addr(24'h000040); push_zeros(4);
        start_cs();
        send_bits(1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_reset("midrst");
        bus.spi_csb = 1'b1;
        repeat (8) @(negedge clk);

`ifdef SPI_FAST_READ_EN
        push_byte(8'h0B); push_addr(24'h000020); push_zeros(8); push_zeros(16);
        expect_read(24'h000020, 2, 1'b0);
        xfer(1'b1, 1'b0);
`else
        e0 = err_cnt; r0 = req_cnt;
        push_byte(8'h0B); push_zeros(8);
        xfer(1'b0, 1'b0);
        chk("err_0b_pulses", 32'(err_cnt - e0), 32'd1);
        chk("req_0b_count", 32'(req_cnt - r0), 32'd0);
`endif

        repeat (10) @(negedge clk);
        chk("addr_queue_drained", 32'(exp_addr_q.size()), 32'd0);
        chk("byte_queue_drained", 32'(exp_byte_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
